// File: rtl/riscv_pkg.sv
// Shared fetch-stage constants, fetch FSM state type and an alignment helper.
package riscv_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_INC   = 32'd4;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between fetch_unit (master) and memory (slave).
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_pc_next.sv
// Next-PC mux (sequential or redirect). FETCH_ALIGN_CHECK_EN selects between
// flagging misaligned redirect targets and silently word-aligning them.
module fetch_pc_next
  import riscv_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        pc_sel,
  input  logic [31:0] target_pc,
  output logic [31:0] next_pc,
  output logic        misalign_fault
);

  logic [31:0] target_s;

`ifdef FETCH_ALIGN_CHECK_EN
  assign target_s       = target_pc;
  assign misalign_fault = pc_sel & ~is_word_aligned(target_pc);
`else
  logic unused_low_s;
  assign target_s       = {target_pc[31:2], 2'b00};
  assign unused_low_s   = ^target_pc[1:0];
  assign misalign_fault = 1'b0;
`endif

  // Redirect wins over the wrapping sequential increment.
  always_comb begin
    next_pc = pc + PC_INC;
    if (pc_sel) begin
      next_pc = target_s;
    end else begin
      next_pc = pc + PC_INC;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding word request, holds the fetched
// instruction until consumed. FETCH_ALIGN_CHECK_EN enables the misalign FAULT state.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  fetch_unit_if.master        imem,
  input  logic                stall,
  input  logic                pc_sel,
  input  logic [31:0]         target_pc,
  output logic [31:0]         inst,
  output logic [31:0]         pc,
  output logic                inst_valid,
  output logic                misalign,
  output logic [31:0]         fetch_count
);

  fetch_state_e state_r;
  fetch_state_e state_next_s;

  logic [31:0] fetch_pc_r;
  logic [31:0] inst_r;
  logic [31:0] pc_r;
  logic [31:0] count_r;
  logic        valid_r;
  logic [31:0] next_pc_s;
  logic        fault_s;
  logic        capture_s;
  logic        consume_s;

  // Data arriving outside FETCH is unsolicited and never captured.
  assign capture_s = (state_r == ST_FETCH) & imem.imem_ready;
  assign consume_s = (state_r == ST_ISSUE) & ~stall;

  fetch_pc_next u_pc_next (
    .pc             (pc_r),
    .pc_sel         (pc_sel),
    .target_pc      (target_pc),
    .next_pc        (next_pc_s),
    .misalign_fault (fault_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (imem.imem_ready) begin
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_ISSUE: begin
        if (stall) begin
          state_next_s = ST_ISSUE;
        end else if (fault_s) begin
`ifdef FETCH_ALIGN_CHECK_EN
          state_next_s = ST_FAULT;
`else
          state_next_s = ST_FETCH;
`endif
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_FAULT: begin
`ifdef FETCH_ALIGN_CHECK_EN
        state_next_s = ST_FAULT;
`else
        state_next_s = ST_FETCH;
`endif
      end
      default: begin
        state_next_s = ST_FETCH;
      end
    endcase
  end

  // Memory request is combinational from state so zero-wait memory can answer at once.
  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = fetch_pc_r;
    if (state_r == ST_FETCH) begin
      imem.imem_req = 1'b1;
    end else begin
      imem.imem_req = 1'b0;
    end
  end

  // Fetch PC, held instruction and consume counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r <= RESET_PC;
      inst_r     <= NOP_INST;
      pc_r       <= RESET_PC;
      valid_r    <= 1'b0;
      count_r    <= 32'd0;
    end else if (capture_s) begin
      inst_r  <= imem.imem_rdata;
      pc_r    <= fetch_pc_r;
      valid_r <= 1'b1;
    end else if (consume_s) begin
      valid_r <= 1'b0;
      count_r <= count_r + 32'd1;
      if (!fault_s) begin
        fetch_pc_r <= next_pc_s;
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
    end else begin
      valid_r <= valid_r;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_r;

  // Sticky fault flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_r <= 1'b0;
    end else if (consume_s && fault_s) begin
      misalign_r <= 1'b1;
    end else begin
      misalign_r <= misalign_r;
    end
  end

  assign misalign = misalign_r;
`else
  assign misalign = 1'b0;
`endif

  assign inst        = inst_r;
  assign pc          = pc_r;
  assign inst_valid  = valid_r;
  assign fetch_count = count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a transaction-level model tracks the expected
// PC stream and consume count while a memory model answers with random wait states.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        pc_sel = 1'b0;
  logic [31:0] target_pc = 32'd0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic        misalign;
  logic [31:0] fetch_count;

  fetch_unit_if imem_bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem_bus),
    .stall       (stall),
    .pc_sel      (pc_sel),
    .target_pc   (target_pc),
    .inst        (inst),
    .pc          (pc),
    .inst_valid  (inst_valid),
    .misalign    (misalign),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_count;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h0020_8033;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_inst"}, inst, NOP);
    check_val({tag, "_pc"}, pc, 32'd0);
    check_val({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
    check_val({tag, "_misalign"}, {31'd0, misalign}, 32'd0);
    check_val({tag, "_count"}, fetch_count, 32'd0);
  endtask

  // One instruction: request, wait states, capture, stall hold, consume.
  task automatic fetch_one(input int wait_n, input int stall_n, input bit sel,
                           input logic [31:0] tgt, output int unsigned cap_cyc,
                           output bit faulted);
    bit fault;
    check_val("req", {31'd0, imem_bus.imem_req}, 32'd1);
    check_val("addr", imem_bus.imem_addr, exp_pc);
    for (int w = 0; w < wait_n; w++) begin
      imem_bus.imem_ready = 1'b0;
      imem_bus.imem_rdata = $urandom;
      stall  = 1'($urandom_range(0, 1));
      pc_sel = 1'($urandom_range(0, 1));
      tick();
      check_val("req_hold", {31'd0, imem_bus.imem_req}, 32'd1);
      check_val("addr_hold", imem_bus.imem_addr, exp_pc);
      check_val("wait_valid", {31'd0, inst_valid}, 32'd0);
    end
    imem_bus.imem_ready = 1'b1;
    imem_bus.imem_rdata = mem_word(exp_pc);
    tick();
    cap_cyc = cyc_cnt;
    imem_bus.imem_ready = 1'b0;
    check_val("cap_valid", {31'd0, inst_valid}, 32'd1);
    check_val("cap_inst", inst, mem_word(exp_pc));
    check_val("cap_pc", pc, exp_pc);
    check_val("issue_req", {31'd0, imem_bus.imem_req}, 32'd0);
    for (int s = 0; s < stall_n; s++) begin
      stall = 1'b1;
      pc_sel = 1'($urandom_range(0, 1));
      target_pc = $urandom;
      imem_bus.imem_ready = 1'($urandom_range(0, 1));
      imem_bus.imem_rdata = $urandom;
      tick();
      check_val("stall_valid", {31'd0, inst_valid}, 32'd1);
      check_val("stall_inst", inst, mem_word(exp_pc));
      check_val("stall_pc", pc, exp_pc);
      check_val("stall_req", {31'd0, imem_bus.imem_req}, 32'd0);
      check_val("stall_count", fetch_count, exp_count);
    end
    stall = 1'b0;
    pc_sel = sel;
    target_pc = tgt;
    imem_bus.imem_ready = 1'($urandom_range(0, 1));
    imem_bus.imem_rdata = $urandom;
    tick();
    imem_bus.imem_ready = 1'b0;
    stall  = 1'($urandom_range(0, 1));
    pc_sel = 1'($urandom_range(0, 1));
    exp_count = exp_count + 32'd1;
`ifdef FETCH_ALIGN_CHECK_EN
    fault = sel && (tgt[1:0] != 2'b00);
`else
    fault = 1'b0;
`endif
    if (!fault) exp_pc = sel ? (tgt & 32'hFFFF_FFFC) : exp_pc + 32'd4;
    check_val("consume_count", fetch_count, exp_count);
    check_val("consume_valid", {31'd0, inst_valid}, 32'd0);
    check_val("consume_misalign", {31'd0, misalign}, {31'd0, fault});
    check_val("consume_req", {31'd0, imem_bus.imem_req}, {31'd0, !fault});
    if (!fault) check_val("next_addr", imem_bus.imem_addr, exp_pc);
    faulted = fault;
  endtask

  initial begin
    int unsigned c0, c1, c2, c3, rst_cyc;
    bit f;
    logic [31:0] tgt;

    imem_bus.imem_ready = 1'b0;
    imem_bus.imem_rdata = 32'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    rst_cyc = cyc_cnt;
    exp_pc = 32'd0;
    exp_count = 32'd0;

    // First fetch, zero-wait memory.
    fetch_one(0, 0, 1'b0, 32'd0, c0, f);
    check_val("first_latency", c0 - rst_cyc, 32'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_pc = 32'd0;
    exp_count = 32'd0;

    // Two wait states: PCs 0, 4, 8 four cycles apart; redirect at 8 after a long stall.
    fetch_one(2, 0, 1'b0, 32'd0, c1, f);
    fetch_one(2, 0, 1'b0, 32'd0, c2, f);
    check_val("spacing_1", c2 - c1, 32'd4);
    fetch_one(2, 5, 1'b1, 32'h0000_0100, c3, f);
    check_val("spacing_2", c3 - c2, 32'd4);
    check_val("count_3", fetch_count, 32'd3);
    check_val("redirect_addr", imem_bus.imem_addr, 32'h0000_0100);

    fetch_one(1, 0, 1'b1, 32'hFFFF_FFFC, c0, f);
    fetch_one(0, 1, 1'b0, 32'd0, c0, f);
    check_val("wrap_addr", imem_bus.imem_addr, 32'h0000_0000);

    for (int i = 0; i < 40; i++) begin
      tgt = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
      tgt = tgt & 32'hFFFF_FFFC;
`endif
      fetch_one($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), tgt, c0, f);
    end

    // Misaligned redirect target.
    fetch_one(0, 0, 1'b1, 32'h0000_0102, c0, f);
`ifdef FETCH_ALIGN_CHECK_EN
    for (int k = 0; k < 3; k++) begin
      imem_bus.imem_ready = 1'($urandom_range(0, 1));
      tick();
      check_val("fault_misalign", {31'd0, misalign}, 32'd1);
      check_val("fault_req", {31'd0, imem_bus.imem_req}, 32'd0);
      check_val("fault_valid", {31'd0, inst_valid}, 32'd0);
    end
    imem_bus.imem_ready = 1'b0;
`else
    check_val("misalign_redir", imem_bus.imem_addr, 32'h0000_0100);
`endif

    // Reset during a wait cycle, with a stray ready pulse as reset releases.
    imem_bus.imem_ready = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_val("async_count", fetch_count, 32'd0);
    check_val("async_valid", {31'd0, inst_valid}, 32'd0);
    imem_bus.imem_ready = 1'b1;
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_reset_vals("midreset");
    rst = 1'b0;
    imem_bus.imem_ready = 1'b0;
    exp_pc = 32'd0;
    exp_count = 32'd0;
    tick();
    check_val("stray_valid", {31'd0, inst_valid}, 32'd0);
    check_val("stray_inst", inst, NOP);
    fetch_one(1, 0, 1'b0, 32'd0, c0, f);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
